axonerve_kvs_resp_model: RTL and testbench

- Synthesizable responder model of the Axonerve KVS command interface: accepts the I_CMD_* command stream and returns O_ACK with hit/error results.
- Backed by a small register-based key/value table, so kernel-level benches, host-interface logic and FPGA bring-up can run without the CAM IP.
- Drop-in behavioural replacement at the same boundary as axonerve_kvs_kernel (single-clock subset).

---
 rtl/axonerve_kvs_resp_model_if.sv | 46 ++++
 rtl/axonerve_kvs_resp_model.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axonerve_kvs_resp_model.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axonerve_kvs_resp_model_if.sv
// Command/response bundle between a host and the Axonerve KVS responder model.
// The master side issues commands; the slave side returns acks and results.
interface axonerve_kvs_resp_model_if;
  // response / status side
  logic [31:0]  version;
  logic         ready;
  logic         init_wait;
  logic         ack;
  logic         ent_err;
  logic         single_hit;
  logic         multi_hit;
  logic [127:0] res_key;
  logic [127:0] res_msk;
  logic [6:0]   res_pri;
  logic [31:0]  res_value;
  logic         cmd_empty;
  logic         cmd_full;
  logic         ent_full;
  logic [31:0]  kernel_status;
  // command side
  logic         cmd_init;
  logic         cmd_valid;
  logic         cmd_erase;
  logic         cmd_write;
  logic         cmd_read;
  logic         cmd_search;
  logic         cmd_update;
  logic [127:0] cmd_key;
  logic [127:0] cmd_msk;
  logic [6:0]   cmd_pri;
  logic [31:0]  cmd_value;

  modport master (
    output cmd_init, cmd_valid, cmd_erase, cmd_write, cmd_read, cmd_search, cmd_update,
           cmd_key, cmd_msk, cmd_pri, cmd_value,
    input  version, ready, init_wait, ack, ent_err, single_hit, multi_hit,
           res_key, res_msk, res_pri, res_value, cmd_empty, cmd_full, ent_full, kernel_status
  );

  modport slave (
    input  cmd_init, cmd_valid, cmd_erase, cmd_write, cmd_read, cmd_search, cmd_update,
           cmd_key, cmd_msk, cmd_pri, cmd_value,
    output version, ready, init_wait, ack, ent_err, single_hit, multi_hit,
           res_key, res_msk, res_pri, res_value, cmd_empty, cmd_full, ent_full, kernel_status
  );
endinterface

// File: rtl/axonerve_kvs_resp_model.sv
// Register-based responder standing in for the Axonerve KVS CAM kernel.
// Commands enter a small FIFO and are executed one per cycle against a
// ternary key/value table; each execution produces a one-cycle ack.
module axonerve_kvs_resp_model #(
  parameter int          ENTRIES    = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input logic clk,
  input logic rst,
  axonerve_kvs_resp_model_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ENTRIES + 1);

  // opcode bit order: {erase, write, read, search, update}
  localparam logic [4:0] OP_ERASE  = 5'b10000;
  localparam logic [4:0] OP_WRITE  = 5'b01000;
  localparam logic [4:0] OP_READ   = 5'b00100;
  localparam logic [4:0] OP_SEARCH = 5'b00010;
  localparam logic [4:0] OP_UPDATE = 5'b00001;

  typedef struct packed {
    logic [4:0]   op;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
  } cmd_t;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_reg;
  logic [IW-1:0] clr_idx_reg;
  logic          ready_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [ENTRIES-1:0] valid_reg;
  logic          ack_reg, err_reg, single_reg, multi_reg, ent_full_reg;
  logic [127:0]  key_reg, msk_reg;
  logic [6:0]    pri_reg;
  logic [31:0]   val_reg;
  logic [15:0]   ack_cnt_reg, drop_cnt_reg;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [127:0]  tbl_key  [ENTRIES];
  logic [127:0]  tbl_msk  [ENTRIES];
  logic [6:0]    tbl_pri  [ENTRIES];
  logic [31:0]   tbl_val  [ENTRIES];

  logic          fifo_full, fifo_empty, push, exec;
  cmd_t          cmd_in, head;
  logic [ENTRIES-1:0] match;
  logic [IW-1:0] hit_idx, free_idx, tgt;
  logic          hit_any, free_any;
  logic [CW-1:0] hit_cnt;
  logic          nxt_err, nxt_single, nxt_multi, wr_en, upd_en, ers_en, do_write;
  logic [127:0]  nxt_key, nxt_msk;
  logic [6:0]    nxt_pri;
  logic [31:0]   nxt_val;
  logic [IW-1:0] rd_idx;

  assign fifo_full  = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  // INIT wins over a same-cycle command, so it blocks both push and execute
  assign push   = bus.cmd_valid & ready_reg & ~fifo_full & ~bus.cmd_init;
  assign exec   = ready_reg & ~fifo_empty & ~bus.cmd_init;
  assign cmd_in = {bus.cmd_erase, bus.cmd_write, bus.cmd_read, bus.cmd_search, bus.cmd_update,
                   bus.cmd_key, bus.cmd_msk, bus.cmd_pri, bus.cmd_value};
  assign head   = fifo_mem[rd_ptr_reg];
  assign rd_idx = head.val[IW-1:0];

  // ternary match of the FIFO head against every valid entry, plus lowest hit / lowest free
  always_comb begin
    match    = '0;
    hit_idx  = '0;
    free_idx = '0;
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_cnt  = '0;
    for (int i = 0; i < ENTRIES; i++)
      match[i] = valid_reg[i] && (((tbl_key[i] ^ head.key) & ~head.msk) == 128'd0);
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_idx = IW'(i);
        hit_any = 1'b1;
      end
      if (!valid_reg[i]) begin
        free_idx = IW'(i);
        free_any = 1'b1;
      end
      hit_cnt = hit_cnt + CW'(match[i]);
    end
  end

  // per-opcode result and table-change decode for the FIFO head
  always_comb begin
    nxt_err    = 1'b0;
    nxt_single = (hit_cnt == CW'(1));
    nxt_multi  = (hit_cnt > CW'(1));
    nxt_key    = head.key;
    nxt_msk    = head.msk;
    nxt_pri    = head.pri;
    nxt_val    = head.val;
    tgt        = hit_idx;
    do_write   = 1'b0;
    wr_en      = 1'b0;
    upd_en     = 1'b0;
    ers_en     = 1'b0;
    case (head.op)
      OP_SEARCH: begin
        if (hit_any) begin
          nxt_key = tbl_key[hit_idx];
          nxt_msk = tbl_msk[hit_idx];
          nxt_pri = tbl_pri[hit_idx];
          nxt_val = tbl_val[hit_idx];
        end else begin
          nxt_val = '0;
        end
      end
      OP_WRITE: do_write = 1'b1;
      OP_UPDATE: begin
        if (hit_any) begin
          upd_en  = 1'b1;
          nxt_key = tbl_key[hit_idx];
          nxt_msk = tbl_msk[hit_idx];
          nxt_pri = tbl_pri[hit_idx];
        end else begin
          do_write = 1'b1;
        end
      end
      OP_ERASE: begin
        if (hit_any) begin
          ers_en  = 1'b1;
          nxt_key = tbl_key[hit_idx];
          nxt_msk = tbl_msk[hit_idx];
          nxt_pri = tbl_pri[hit_idx];
          nxt_val = tbl_val[hit_idx];
        end else begin
          nxt_err = 1'b1;
        end
      end
      OP_READ: begin
        tgt        = rd_idx;
        nxt_key    = tbl_key[rd_idx];
        nxt_msk    = tbl_msk[rd_idx];
        nxt_pri    = tbl_pri[rd_idx];
        nxt_val    = tbl_val[rd_idx];
        nxt_err    = ~valid_reg[rd_idx];
        nxt_single = 1'b0;
        nxt_multi  = 1'b0;
      end
      default: begin
        nxt_err    = 1'b1;
        nxt_single = 1'b0;
        nxt_multi  = 1'b0;
      end
    endcase
    if (do_write) begin
      if (free_any) begin
        wr_en = 1'b1;
        tgt   = free_idx;
      end else begin
        nxt_err = 1'b1;
      end
    end
  end

  // control FSM, FIFO pointers, valid bits, registered results and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_idx_reg  <= '0;
      ready_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      valid_reg    <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      single_reg   <= 1'b0;
      multi_reg    <= 1'b0;
      key_reg      <= '0;
      msk_reg      <= '0;
      pri_reg      <= '0;
      val_reg      <= '0;
      ent_full_reg <= 1'b0;
      ack_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      ack_reg      <= 1'b0;
      ent_full_reg <= &valid_reg;
      count_reg    <= count_reg + (PW+1)'(push) - (PW+1)'(exec);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (exec) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (bus.cmd_valid && !push && drop_cnt_reg != 16'hffff)
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      case (state_reg)
        ST_CLEAR: begin
          valid_reg[clr_idx_reg] <= 1'b0;
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (clr_idx_reg == IW'(ENTRIES - 1)) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          if (bus.cmd_init) begin
            state_reg   <= ST_CLEAR;
            ready_reg   <= 1'b0;
            clr_idx_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
          end else if (exec) begin
            ack_reg    <= 1'b1;
            err_reg    <= nxt_err;
            single_reg <= nxt_single;
            multi_reg  <= nxt_multi;
            key_reg    <= nxt_key;
            msk_reg    <= nxt_msk;
            pri_reg    <= nxt_pri;
            val_reg    <= nxt_val;
            if (wr_en)  valid_reg[tgt] <= 1'b1;
            if (ers_en) valid_reg[tgt] <= 1'b0;
            if (ack_cnt_reg != 16'hffff) ack_cnt_reg <= ack_cnt_reg + 16'd1;
          end
        end
      endcase
    end
  end

  // FIFO and table payload storage (no reset; validity is tracked separately)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= cmd_in;
    if (exec && wr_en) begin
      tbl_key[tgt] <= head.key;
      tbl_msk[tgt] <= head.msk;
      tbl_pri[tgt] <= head.pri;
      tbl_val[tgt] <= head.val;
    end
    if (exec && upd_en) tbl_val[tgt] <= head.val;
  end

  assign bus.version       = VERSION;
  assign bus.ready         = ready_reg;
  assign bus.init_wait     = ~ready_reg;
  assign bus.ack           = ack_reg;
  assign bus.ent_err       = err_reg;
  assign bus.single_hit    = single_reg;
  assign bus.multi_hit     = multi_reg;
  assign bus.res_key       = key_reg;
  assign bus.res_msk       = msk_reg;
  assign bus.res_pri       = pri_reg;
  assign bus.res_value     = val_reg;
  assign bus.cmd_empty     = fifo_empty;
  assign bus.cmd_full      = fifo_full;
  assign bus.ent_full      = ent_full_reg;
  assign bus.kernel_status = {drop_cnt_reg, ack_cnt_reg};
endmodule

// File: tb/tb_axonerve_kvs_resp_model.sv
// Self-checking bench for axonerve_kvs_resp_model: a transaction-level table
// model predicts every cycle's outputs; directed steps pin literal values.
module tb_axonerve_kvs_resp_model;
  localparam int ENTRIES    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam logic [4:0] OP_ERASE  = 5'b10000;
  localparam logic [4:0] OP_WRITE  = 5'b01000;
  localparam logic [4:0] OP_READ   = 5'b00100;
  localparam logic [4:0] OP_SEARCH = 5'b00010;
  localparam logic [4:0] OP_UPDATE = 5'b00001;
  localparam logic [127:0] K1  = {4{32'habadcafe}};
  localparam logic [127:0] KHI = 128'h1234_5678_9abc_def0_0000_0000_0000_0000;

  typedef struct packed {
    logic [4:0]   op;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
  } cmd_t;

  typedef struct {
    logic        err;
    logic        single;
    logic        multi;
    logic [31:0] val;
    int          cyc;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ack_t acks[$];

  axonerve_kvs_resp_model_if bus();

  axonerve_kvs_resp_model #(.ENTRIES(ENTRIES), .FIFO_DEPTH(FIFO_DEPTH), .VERSION(32'h0001_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  cmd_t         q[$];
  bit           m_valid [ENTRIES];
  logic [127:0] m_key [ENTRIES];
  logic [127:0] m_msk [ENTRIES];
  logic [6:0]   m_pri [ENTRIES];
  logic [31:0]  m_val [ENTRIES];
  bit           m_ready, m_ack, m_entfull;
  int           m_clr;
  logic [15:0]  m_acks, m_drops;
  logic         e_err, e_single, e_multi, e_dchk;
  logic [127:0] e_key, e_msk;
  logic [6:0]   e_pri;
  logic [31:0]  e_val;

  task automatic model_exec(input cmd_t c);
    int hits = 0;
    int sel = -1;
    int fr = -1;
    int idx;
    bit do_wr = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && (((m_key[i] ^ c.key) & ~c.msk) == 0)) begin
        hits++;
        if (sel < 0) sel = i;
      end
      if (!m_valid[i] && fr < 0) fr = i;
    end
    e_err = 0; e_single = (hits == 1); e_multi = (hits >= 2); e_dchk = 1;
    e_key = c.key; e_msk = c.msk; e_pri = c.pri; e_val = c.val;
    case (c.op)
      OP_SEARCH: if (sel >= 0) begin
                   e_key = m_key[sel]; e_msk = m_msk[sel]; e_pri = m_pri[sel]; e_val = m_val[sel];
                 end else e_val = 0;
      OP_WRITE:  do_wr = 1;
      OP_UPDATE: if (sel >= 0) begin
                   m_val[sel] = c.val;
                   e_key = m_key[sel]; e_msk = m_msk[sel]; e_pri = m_pri[sel];
                 end else do_wr = 1;
      OP_ERASE:  if (sel >= 0) begin
                   e_key = m_key[sel]; e_msk = m_msk[sel]; e_pri = m_pri[sel]; e_val = m_val[sel];
                   m_valid[sel] = 0;
                 end else e_err = 1;
      OP_READ: begin
        idx = int'(c.val) % ENTRIES;
        e_single = 0; e_multi = 0;
        if (m_valid[idx]) begin
          e_key = m_key[idx]; e_msk = m_msk[idx]; e_pri = m_pri[idx]; e_val = m_val[idx];
        end else begin
          e_err = 1; e_dchk = 0;
        end
      end
      default: begin e_err = 1; e_single = 0; e_multi = 0; e_dchk = 0; end
    endcase
    if (do_wr) begin
      if (fr >= 0) begin
        m_valid[fr] = 1; m_key[fr] = c.key; m_msk[fr] = c.msk; m_pri[fr] = c.pri; m_val[fr] = c.val;
      end else e_err = 1;
    end
  endtask

  // model advances on every edge; async reset returns it to its initial state
  always @(posedge clk or posedge rst) begin
    bit pushed, full_b, allv;
    cmd_t cur, c;
    if (rst) begin
      q.delete();
      m_ready = 0; m_clr = ENTRIES; m_ack = 0; m_acks = 0; m_drops = 0; m_entfull = 0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else begin
      cur = {bus.cmd_erase, bus.cmd_write, bus.cmd_read, bus.cmd_search, bus.cmd_update,
             bus.cmd_key, bus.cmd_msk, bus.cmd_pri, bus.cmd_value};
      full_b = (q.size() == FIFO_DEPTH);
      pushed = 0;
      m_ack = 0;
      allv = 1;
      for (int i = 0; i < ENTRIES; i++) allv = allv & m_valid[i];
      m_entfull = allv;
      if (!m_ready) begin
        m_clr--;
        if (m_clr == 0) m_ready = 1;
      end else if (bus.cmd_init) begin
        q.delete();
        m_ready = 0; m_clr = ENTRIES;
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      end else begin
        if (q.size() > 0) begin
          c = q.pop_front();
          model_exec(c);
          m_ack = 1;
          if (m_acks != 16'hffff) m_acks++;
        end
        if (bus.cmd_valid && !full_b) begin
          q.push_back(cur);
          pushed = 1;
        end
      end
      if (bus.cmd_valid && !pushed && m_drops != 16'hffff) m_drops++;
    end
  end

  // compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", bus.ready, m_ready);
      chk("wait", bus.init_wait, !m_ready);
      chk("cmd_empty", bus.cmd_empty, q.size() == 0);
      chk("cmd_full", bus.cmd_full, q.size() == FIFO_DEPTH);
      if (m_ready) chk("ent_full", bus.ent_full, m_entfull);
      chk("status", bus.kernel_status, {m_drops, m_acks});
      chk("ack", bus.ack, m_ack);
      if (bus.ack) begin
        acks.push_back('{bus.ent_err, bus.single_hit, bus.multi_hit, bus.res_value, cyc});
        $display("ack cyc=%0d err=%0b single=%0b multi=%0b value=%h",
                 cyc, bus.ent_err, bus.single_hit, bus.multi_hit, bus.res_value);
      end
      if (m_ack) begin
        chk("ent_err", bus.ent_err, e_err);
        chk("single_hit", bus.single_hit, e_single);
        chk("multi_hit", bus.multi_hit, e_multi);
        if (e_dchk) begin
          chk("res_key", bus.res_key, e_key);
          chk("res_msk", bus.res_msk, e_msk);
          chk("res_pri", bus.res_pri, e_pri);
          chk("res_value", bus.res_value, e_val);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic ini, input logic [4:0] op,
                       input logic [127:0] k, input logic [127:0] m,
                       input logic [6:0] p, input logic [31:0] val);
    bus.cmd_valid = v;
    bus.cmd_init  = ini;
    {bus.cmd_erase, bus.cmd_write, bus.cmd_read, bus.cmd_search, bus.cmd_update} = op;
    bus.cmd_key = k; bus.cmd_msk = m; bus.cmd_pri = p; bus.cmd_value = val;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'b0, '0, '0, '0, '0);
  endtask

  task automatic wait_acks(input int n);
    int b = 0;
    while (acks.size() < n && b < 60) begin @(negedge clk); b++; end
    if (acks.size() < n) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=%0d required=%0d", acks.size(), n);
    end
  endtask

  task automatic count_wait(input string nm);
    int n = 0;
    while (bus.init_wait && n < 100) begin n++; @(negedge clk); end
    chk(nm, n, 16);
  endtask

  task automatic check_reset_values();
    chk("rst_version", bus.version, 32'h0001_0000);
    chk("rst_ready", bus.ready, 0);
    chk("rst_wait", bus.init_wait, 1);
    chk("rst_ack", bus.ack, 0);
    chk("rst_empty", bus.cmd_empty, 1);
    chk("rst_full", bus.cmd_full, 0);
    chk("rst_ent_full", bus.ent_full, 0);
    chk("rst_status", bus.kernel_status, 0);
    chk("rst_value", bus.res_value, 0);
  endtask

  initial begin
    int c0;
    logic [4:0] op;
    int r;
    bus.cmd_valid = 0; bus.cmd_init = 0;
    {bus.cmd_erase, bus.cmd_write, bus.cmd_read, bus.cmd_search, bus.cmd_update} = '0;
    bus.cmd_key = '0; bus.cmd_msk = '0; bus.cmd_pri = '0; bus.cmd_value = '0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 0;
    count_wait("reset_wait_cycles");

    // back-to-back write then search
    acks.delete();
    c0 = cyc;
    drive(1, 0, OP_WRITE, K1, '0, 7'd3, 32'h34343434);
    drive(1, 0, OP_SEARCH, K1, '0, 7'd0, 32'h0);
    idle(4);
    wait_acks(2);
    chk("wr_err", acks[0].err, 0);
    chk("wr_latency", acks[0].cyc, c0 + 2);
    chk("srch_consecutive", acks[1].cyc, acks[0].cyc + 1);
    chk("srch_single", acks[1].single, 1);
    chk("srch_value", acks[1].val, 32'h34343434);

    // update then search
    acks.delete();
    drive(1, 0, OP_UPDATE, K1, '0, 7'd0, 32'hfefefefe);
    drive(1, 0, OP_SEARCH, K1, '0, 7'd0, 32'h0);
    idle(4);
    wait_acks(2);
    chk("upd_search_value", acks[1].val, 32'hfefefefe);

    // erase hit, erase miss, search miss
    acks.delete();
    drive(1, 0, OP_ERASE, K1, '0, 7'd0, 32'h0);
    drive(1, 0, OP_ERASE, '0, '0, 7'd0, 32'h0);
    drive(1, 0, OP_SEARCH, K1, '0, 7'd0, 32'h0);
    idle(4);
    wait_acks(3);
    chk("erase_hit_err", acks[0].err, 0);
    chk("erase_miss_err", acks[1].err, 1);
    chk("search_miss_single", acks[2].single, 0);
    chk("search_miss_multi", acks[2].multi, 0);

    // multi-hit via mask, then update-miss acting as write
    acks.delete();
    drive(1, 0, OP_WRITE, KHI, '0, 7'd1, 32'd1);
    drive(1, 0, OP_WRITE, KHI | 128'd1, '0, 7'd2, 32'd2);
    drive(1, 0, OP_SEARCH, KHI, 128'd1, 7'd0, 32'd0);
    drive(1, 0, OP_UPDATE, K1, '0, 7'd4, 32'd5);
    drive(1, 0, OP_SEARCH, K1, '0, 7'd0, 32'd0);
    idle(4);
    wait_acks(5);
    chk("multi_hit", acks[2].multi, 1);
    chk("multi_value_idx0", acks[2].val, 1);
    chk("upd_miss_search_single", acks[4].single, 1);
    chk("upd_miss_search_value", acks[4].val, 5);

    // INIT, then 8 commands held during CLEAR are dropped
    drive(0, 1, 5'b0, '0, '0, '0, '0);
    for (int i = 0; i < 8; i++) drive(1, 0, OP_WRITE, K1, '0, '0, '0);
    idle(1);
    while (bus.init_wait) @(negedge clk);
    chk("drop_count", bus.kernel_status[31:16], 16'd8);

    // fill the table, then one write too many
    acks.delete();
    for (int i = 0; i < ENTRIES; i++) drive(1, 0, OP_WRITE, KHI | 128'(i), '0, 7'(i), 32'(i + 100));
    idle(4);
    chk("ent_full_after_fill", bus.ent_full, 1);
    drive(1, 0, OP_WRITE, K1, '0, '0, 32'd7);
    idle(4);
    wait_acks(ENTRIES + 1);
    chk("write_when_full_err", acks[ENTRIES].err, 1);

    // four pushes then INIT: the last is still queued and gets flushed
    acks.delete();
    for (int i = 0; i < 4; i++) drive(1, 0, OP_SEARCH, KHI | 128'(i), '0, '0, '0);
    drive(0, 1, 5'b0, '0, '0, '0, '0);
    count_wait("init_wait_cycles");
    idle(4);
    chk("flush_ack_count", acks.size(), 3);

    // randomized traffic with a mid-stream asynchronous reset
    for (int n = 0; n < 900; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 5) ? OP_WRITE : (r < 9) ? OP_SEARCH : (r < 12) ? OP_ERASE :
           (r < 15) ? OP_UPDATE : (r < 18) ? OP_READ : 5'($urandom);
      if (n == 600) begin
        #2 rst = 1;
        #1 check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 150) == 0, op,
            KHI | 128'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0) ? 128'($urandom_range(0, 3)) : 128'd0,
            7'($urandom), $urandom);
    end
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
